// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the hazard controller slice.
package pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam int          MDU_LAT_DEF = 4;
    localparam int          PERF_W_DEF  = 16;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_mdu_seq.sv
// Multi-cycle mul/div sequencer: launch pulse, busy FSM and latency counter.
module hazard_mdu_seq
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_mdu_op,
    input  logic i_block,
    output logic o_start,
    output logic o_busy
);

    localparam int CNT_W = $clog2(MDU_LAT);

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_start;

    // A launch is suppressed by a load-use stall or a wrong-path op.
    assign w_start = rst_n & (r_state == IDLE) & i_mdu_op & ~i_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_W'(MDU_LAT - 1);
                        r_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_start = w_start;
    assign o_busy  = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU stalls, branch flushes, stall perf counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int PERF_W  = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rf_raddr0_ID,
    input  logic [4:0]        rf_raddr1_ID,
    input  logic              rf_ren0_ID,
    input  logic              rf_ren1_ID,
    input  logic              rf_wen_EX,
    input  logic [4:0]        rf_waddr_EX,
    input  logic              mem_ren_EX,
    input  logic              mdu_op_ID,
    input  logic              mdu_rd_ID,
    input  logic              branch_taken_EX,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mdu_start,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    logic              w_lu;
    logic              w_md;
    logic              w_stall;
    logic              w_busy;
    logic [PERF_W-1:0] r_perf;

    assign w_lu = mem_ren_EX & rf_wen_EX & (rf_waddr_EX != REG_ZERO) &
                  ((rf_ren0_ID & (rf_raddr0_ID == rf_waddr_EX)) |
                   (rf_ren1_ID & (rf_raddr1_ID == rf_waddr_EX)));

    hazard_mdu_seq #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_mdu_op (mdu_op_ID),
        .i_block  (w_lu | branch_taken_EX),
        .o_start  (mdu_start),
        .o_busy   (w_busy)
    );

    assign w_md    = w_busy & (mdu_op_ID | mdu_rd_ID);
    assign w_stall = w_lu | w_md;

    // Taken branch wins: the ID instruction is wrong-path, so flush instead of stall.
    assign pc_write   = ~rst_n | branch_taken_EX | ~w_stall;
    assign ifid_write = ~rst_n | branch_taken_EX | ~w_stall;
    assign ifid_flush = rst_n & branch_taken_EX;
    assign idex_flush = rst_n & (branch_taken_EX | w_stall);
    assign mdu_busy   = w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (perf_clr) begin
            r_perf <= '0;
        end else if (w_stall & ~branch_taken_EX & (r_perf != '1)) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_stall_cnt = r_perf;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int LAT = 4;
    localparam int PW  = 4;
    localparam int VW  = 6 + PW;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rf_raddr0_ID, rf_raddr1_ID, rf_waddr_EX;
    logic          rf_ren0_ID, rf_ren1_ID, rf_wen_EX, mem_ren_EX;
    logic          mdu_op_ID, mdu_rd_ID, branch_taken_EX, perf_clr;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy;
    logic [PW-1:0] perf_stall_cnt;

    int unsigned   errors = 0;
    int unsigned   checks = 0;

    // Model state: cycles of MDU work left, and the ideal stall count.
    int            m_left;
    int            m_perf;
    logic          e_lu, e_md, e_start, e_stall;
    logic [VW-1:0] exp_v;
    logic [VW-1:0] obs_v;

    hazard_ctrl #(
        .MDU_LAT (LAT),
        .PERF_W  (PW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rf_raddr0_ID    (rf_raddr0_ID),
        .rf_raddr1_ID    (rf_raddr1_ID),
        .rf_ren0_ID      (rf_ren0_ID),
        .rf_ren1_ID      (rf_ren1_ID),
        .rf_wen_EX       (rf_wen_EX),
        .rf_waddr_EX     (rf_waddr_EX),
        .mem_ren_EX      (mem_ren_EX),
        .mdu_op_ID       (mdu_op_ID),
        .mdu_rd_ID       (mdu_rd_ID),
        .branch_taken_EX (branch_taken_EX),
        .perf_clr        (perf_clr),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .mdu_start       (mdu_start),
        .mdu_busy        (mdu_busy),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs_v = {pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy, perf_stall_cnt};

    task automatic model_eval();
        logic busy;
        e_lu = mem_ren_EX && rf_wen_EX && (rf_waddr_EX != 0) &&
               ((rf_ren0_ID && rf_raddr0_ID == rf_waddr_EX) ||
                (rf_ren1_ID && rf_raddr1_ID == rf_waddr_EX));
        busy    = (m_left > 0);
        e_md    = busy && (mdu_op_ID || mdu_rd_ID);
        e_stall = e_lu || e_md;
        e_start = !busy && mdu_op_ID && !e_lu && !branch_taken_EX;
        if (!rst_n) begin
            exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW'(0)};
        end else if (branch_taken_EX) begin
            exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, busy, PW'(m_perf)};
        end else begin
            exp_v = {!e_stall, !e_stall, 1'b0, e_stall, e_start, busy, PW'(m_perf)};
        end
    endtask

    task automatic model_advance();
        model_eval();
        if (!rst_n) begin
            m_left = 0;
            m_perf = 0;
        end else begin
            if (perf_clr)
                m_perf = 0;
            else if (e_stall && !branch_taken_EX && m_perf < PMAX)
                m_perf = m_perf + 1;
            if (e_start)
                m_left = LAT;
            else if (m_left > 0)
                m_left = m_left - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rf_raddr0_ID = 5'd0; rf_raddr1_ID = 5'd0; rf_waddr_EX = 5'd0;
        rf_ren0_ID = 1'b0; rf_ren1_ID = 1'b0; rf_wen_EX = 1'b0; mem_ren_EX = 1'b0;
        mdu_op_ID = 1'b0; mdu_rd_ID = 1'b0; branch_taken_EX = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic load_use_inputs(input logic [4:0] dst, input logic [4:0] rs);
        idle_inputs();
        mem_ren_EX = 1'b1; rf_wen_EX = 1'b1; rf_waddr_EX = dst;
        rf_ren0_ID = 1'b1; rf_raddr0_ID = rs; rf_ren1_ID = 1'b1; rf_raddr1_ID = 5'd17;
    endtask

    task automatic clear_perf();
        idle_inputs();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_use_inputs(5'd8, 5'd8);
        mdu_op_ID = 1'b1;
        m_left = 0; m_perf = 0;
        #1;
        model_eval();
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs_v, exp_v);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        model_eval();
        checks++;
        if (obs_v !== {6'b110000, PW'(0)}) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", obs_v, {6'b110000, PW'(0)});
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_perf();
        load_use_inputs(5'd8, 5'd8);
        #1;
        model_eval();
        checks++;
        if (obs_v !== exp_v || obs_v[VW-1 -: 6] !== 6'b000100) begin
            errors++;
            $display("FAIL load_use_stall: got %b want %b", obs_v, exp_v);
        end
        tick();
        idle_inputs();
        rf_ren0_ID = 1'b1; rf_raddr0_ID = 5'd8;
        #1;
        model_eval();
        checks++;
        if (obs_v !== exp_v || obs_v !== {6'b110000, PW'(1)}) begin
            errors++;
            $display("FAIL load_use_release: got %b want %b", obs_v, {6'b110000, PW'(1)});
        end
        tick();
    endtask

    task automatic test_load_zero();
        load_use_inputs(5'd0, 5'd0);
        #1;
        model_eval();
        checks++;
        if (obs_v[VW-1 -: 6] !== 6'b110000 || obs_v !== exp_v) begin
            errors++;
            $display("FAIL load_to_zero: got %b want %b", obs_v, exp_v);
        end
        tick();
    endtask

    task automatic test_mdu_seq();
        clear_perf();
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            if (c == 0) mdu_op_ID = 1'b1;
            else        mdu_rd_ID = 1'b1;
            #1;
            model_eval();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL mdu_seq_cycle%0d: got %b want %b", c, obs_v, exp_v);
            end
            if (c == 0 || c == 5) begin
                checks++;
                if (mdu_start !== (c == 0) || mdu_busy !== 1'b0 || pc_write !== 1'b1) begin
                    errors++;
                    $display("FAIL mdu_seq_edge%0d: got start=%b busy=%b pc=%b want start=%b busy=0 pc=1",
                             c, mdu_start, mdu_busy, pc_write, (c == 0));
                end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (perf_stall_cnt !== PW'(4)) begin
            errors++;
            $display("FAIL mdu_seq_perf: got %0d want 4", perf_stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 6; c++) begin
            idle_inputs();
            mdu_op_ID = (c <= 5);
            #1;
            model_eval();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL back_to_back_cycle%0d: got %b want %b", c, obs_v, exp_v);
            end
            if (c == 5) begin
                checks++;
                if (mdu_start !== 1'b1 || mdu_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL back_to_back_restart: got start=%b busy=%b want start=1 busy=0",
                             mdu_start, mdu_busy);
                end
            end
            tick();
        end
        for (int c = 0; c < LAT; c++) tick();
    endtask

    task automatic test_branch();
        int perf_before;
        perf_before = m_perf;
        load_use_inputs(5'd9, 5'd9);
        mdu_op_ID = 1'b1;
        branch_taken_EX = 1'b1;
        #1;
        model_eval();
        checks++;
        if (obs_v !== exp_v || obs_v[VW-1 -: 6] !== 6'b111100) begin
            errors++;
            $display("FAIL branch_priority: got %b want %b", obs_v, exp_v);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (perf_stall_cnt !== PW'(perf_before) || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL branch_no_side_effect: got perf=%0d busy=%b want perf=%0d busy=0",
                     perf_stall_cnt, mdu_busy, perf_before);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        mdu_op_ID = 1'b1;
        tick();
        idle_inputs();
        tick();
        load_use_inputs(5'd3, 5'd3);
        mdu_op_ID = 1'b1;
        #1;
        model_eval();
        checks++;
        if (obs_v !== exp_v || mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b want %b", obs_v, exp_v);
        end
        #1;
        rst_n = 1'b0;
        m_left = 0; m_perf = 0;
        #1;
        model_eval();
        checks++;
        if (obs_v !== {6'b110000, PW'(0)}) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b want %b", obs_v, {6'b110000, PW'(0)});
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        mdu_rd_ID = 1'b1;
        #1;
        model_eval();
        checks++;
        if (obs_v !== exp_v || obs_v !== {6'b110000, PW'(0)}) begin
            errors++;
            $display("FAIL after_reset_idle: got %b want %b", obs_v, exp_v);
        end
        tick();
    endtask

    task automatic test_saturation();
        clear_perf();
        for (int c = 0; c < 20; c++) begin
            load_use_inputs(5'd12, 5'd12);
            tick();
        end
        #1;
        checks++;
        if (perf_stall_cnt !== PW'(PMAX) || perf_stall_cnt !== PW'(m_perf)) begin
            errors++;
            $display("FAIL perf_saturate: got %0d want %0d", perf_stall_cnt, PMAX);
        end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        #1;
        checks++;
        if (perf_stall_cnt !== PW'(0)) begin
            errors++;
            $display("FAIL perf_clear_priority: got %0d want 0", perf_stall_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rf_raddr0_ID    = 5'($urandom_range(0, 3));
            rf_raddr1_ID    = 5'($urandom_range(0, 3));
            rf_waddr_EX     = 5'($urandom_range(0, 3));
            rf_ren0_ID      = 1'($urandom_range(0, 1));
            rf_ren1_ID      = 1'($urandom_range(0, 1));
            rf_wen_EX       = 1'($urandom_range(0, 1));
            mem_ren_EX      = 1'($urandom_range(0, 1));
            mdu_op_ID       = ($urandom_range(0, 3) == 0);
            mdu_rd_ID       = ($urandom_range(0, 3) == 0);
            branch_taken_EX = ($urandom_range(0, 7) == 0);
            perf_clr        = ($urandom_range(0, 31) == 0);
            #1;
            model_eval();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b want %b", c, obs_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_load_zero();
        test_mdu_seq();
        test_back_to_back();
        test_branch();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
